// File: rtl/seq_mult10_pkg.sv
// Shared constants and state encoding for the sequential 10x10 multiplier.
package seq_mult10_pkg;

  // Operand width is fixed by the rca10 adder datapath.
  localparam int WIDTH = 10;
  // Iteration counter width; 2**CNT_W must cover WIDTH iterations.
  localparam int CNT_W = 4;
  // Product width.
  localparam int P_W   = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult10_rca10.sv
// 10-bit ripple-carry adder used as the multiplier's add stage.
module seq_mult10_rca10 (
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic       cin,
  output logic [9:0] sum,
  output logic       cout
);

  logic [10:0] c;

  assign c[0] = cin;

  // One full adder per bit, carry rippling from bit 0 upwards.
  for (genvar i = 0; i < 10; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[10];

endmodule

// File: rtl/seq_mult10.sv
// Sequential radix-2 shift-and-add unsigned multiplier, 10x10 -> 20 bits.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE. While
// out_valid is high and out_ready low, P holds its value. in_valid outside
// IDLE and out_ready outside DONE are ignored. Reset wins over any handshake.
module seq_mult10
  import seq_mult10_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  A,
  input  logic [9:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] P,
  output logic [1:0]  dbg_state
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Partial product for this iteration: multiplicand if the current multiplier LSB is set.
  always_comb begin
    addend = '0;
    if (mq[0]) addend = mcand;
  end

  seq_mult10_rca10 u_rca10 (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake outputs; unused encoding falls back to IDLE.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (count == LAST_ITER) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, then add-and-shift once per BUSY cycle.
  // The adder carry-out becomes the new acc_hi MSB, so no product bit is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi <= '0;
      mq     <= '0;
      mcand  <= '0;
      count  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand  <= A;
            mq     <= B;
            acc_hi <= '0;
            count  <= '0;
          end
        end
        S_BUSY: begin
          acc_hi <= {cout, sum[WIDTH-1:1]};
          mq     <= {sum[0], mq[WIDTH-1:1]};
          count  <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Product and state are visible in every state; P is meaningful only in DONE.
  always_comb begin
    P         = {acc_hi, mq};
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_seq_mult10.sv
// Directed and randomised bench for seq_mult10.
module tb_seq_mult10;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  A;
  logic [9:0]  B;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] P;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];

  seq_mult10 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Driver: present operands for one cycle from IDLE, then wait (bounded)
  // for out_valid. Returns at the negedge where out_valid is seen, with
  // lat = number of rising edges after the accept edge.
  task automatic run_op(input logic [9:0] a, input logic [9:0] b,
                        output logic [19:0] p, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom_range(0, 1023);
    B        = $urandom_range(0, 1023);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = P;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b P=%h, want 1 0 00000",
               in_ready, out_valid, P);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_dbg_state: got %0d want 0", dbg_state);
    end
  endtask

  task automatic test_max();
    logic [19:0] p;
    int lat;
    out_ready = 1'b1;
    run_op(10'h3FF, 10'h3FF, p, lat);
    checks++;
    if (p !== 20'hFF801) begin
      errors++;
      $display("FAIL max_product: got %h want FF801", p);
    end
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL max_latency: got %0d want 10", lat);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_return_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_zero_one();
    logic [9:0]  a_v [2] = '{10'h000, 10'h001};
    logic [19:0] e_v [2] = '{20'h00000, 20'h002AB};
    logic [19:0] p;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_op(a_v[i], 10'h2AB, p, lat);
      checks++;
      if (p !== e_v[i]) begin
        errors++;
        $display("FAIL zero_one_product[%0d]: got %h want %h", i, p, e_v[i]);
      end
      checks++;
      if (lat !== 10) begin
        errors++;
        $display("FAIL zero_one_latency[%0d]: got %0d want 10", i, lat);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] p;
    int lat;
    int bad;
    out_ready = 1'b0;
    run_op(10'h155, 10'h0AA, p, lat);
    checks++;
    if (p !== 20'h0E272 || lat !== 10) begin
      errors++;
      $display("FAIL bp_product: got %h lat %0d want 0E272 lat 10", p, lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      if (P !== 20'h0E272 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles lost P/out_valid or raised in_ready (P=%h)", bad, P);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_complete: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [19:0] p;
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    A        = 10'h3FF;
    B        = 10'h3FF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b P=%h want 1 0 00000",
               in_ready, out_valid, P);
    end
    out_ready = 1'b1;
    run_op(10'h200, 10'h002, p, lat);
    checks++;
    if (p !== 20'h00400 || lat !== 10) begin
      errors++;
      $display("FAIL mid_reset_new_op: got %h lat %0d want 00400 lat 10", p, lat);
    end
    @(negedge clk);
  endtask

  // Operands keep changing with in_valid high while BUSY; only the first
  // pair counts. 0x0FF * 0x101 = 255 * 257 = 65535 = 0x0FFFF.
  task automatic test_hold_valid();
    int lat;
    int bad;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    A        = 10'h0FF;
    B        = 10'h101;
    @(negedge clk);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready !== 1'b0) bad++;
      A = $urandom_range(0, 1023);
      B = $urandom_range(0, 1023);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    checks++;
    if (P !== 20'h0FFFF || lat !== 10) begin
      errors++;
      $display("FAIL hold_valid_product: got %h lat %0d want 0FFFF lat 10", P, lat);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_valid_in_ready: high in %0d BUSY cycles, want 0", bad);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [9:0]  a;
    logic [9:0]  b;
    logic [19:0] p;
    logic [19:0] exp_p;
    int lat;
    int stall;
    int got = 0;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom_range(0, 1023);
      b = $urandom_range(0, 1023);
      out_ready = 1'b0;
      run_op(a, b, p, lat);
      exp_q.push_back(20'(a) * 20'(b));
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      checks++;
      if (!out_valid) begin
        errors++;
        $display("FAIL rand_timeout[%0d]: no out_valid for %h*%h", n, a, b);
      end else begin
        got++;
        exp_p = exp_q.pop_front();
        if (P !== exp_p || p !== exp_p) begin
          errors++;
          $display("FAIL rand_product[%0d]: %h*%h got %h (first seen %h) want %h",
                   n, a, b, P, p, exp_p);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (got !== 1000 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_count: got %0d results, %0d left in queue, want 1000 and 0",
               got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_zero_one();
    test_backpressure();
    test_reset_mid();
    test_hold_valid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
